// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Count-update encodings match the {write_accepted, read_accepted} pair.
package sync_fifo_pkg;

   localparam logic [1:0] CNT_HOLD = 2'b00;
   localparam logic [1:0] CNT_INC  = 2'b10;
   localparam logic [1:0] CNT_DEC  = 2'b01;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_param: one synchronous write port and one
// read port, registered by default or combinational with SYNC_FIFO_FWFT_EN.
module sync_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic              rclr,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**AW];

   // Contents are never reset; only written on accepted writes.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

`ifdef SYNC_FIFO_FWFT_EN
   logic unused_rd;
   assign unused_rd = re | rclr;
   assign rdata     = mem_q[raddr];
`else
   logic [DATA_W-1:0] rdata_q;

   // Read register: cleared by reset/flush, holds when no read is accepted.
   always_ff @(posedge clk) begin
      if (rclr)    rdata_q <= '0;
      else if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level flags, sticky errors and flush.
// Optional first-word-fall-through read path: define SYNC_FIFO_FWFT_EN.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int DEPTH    = 16,
   parameter  int AF_LEVEL = DEPTH - 2,
   parameter  int AE_LEVEL = 2,
   localparam int CNT_W    = clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              w_en,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_en,
   output logic [DATA_W-1:0] r_data,
   input  logic              flush,
   input  logic              clr_err,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   localparam int AW = clog2(DEPTH);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] FULLC = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_L  = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_L  = CNT_W'(AE_LEVEL);

   logic [CNT_W-1:0]  w_ptr_q, w_ptr_d;
   logic [CNT_W-1:0]  r_ptr_q, r_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              wa, ra;
   logic              ram_we, ram_re, ram_clr;
   logic [DATA_W-1:0] ram_rd;

   assign full         = (cnt_q == FULLC);
   assign empty        = (cnt_q == '0);
   assign almost_full  = (cnt_q >= AF_L);
   assign almost_empty = (cnt_q <= AE_L);
   assign count        = cnt_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   assign wa      = w_en & ~full;
   assign ra      = r_en & ~empty;
   assign ram_we  = wa & reset_n & ~flush;
   assign ram_re  = ra & reset_n & ~flush;
   assign ram_clr = ~reset_n | flush;

   // Next-state for pointers, occupancy and sticky errors (flush over normal).
   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (flush) begin
         w_ptr_d = '0;
         r_ptr_d = '0;
         cnt_d   = '0;
      end else begin
         if (wa) w_ptr_d = w_ptr_q + ONE;
         if (ra) r_ptr_d = r_ptr_q + ONE;
         case ({wa, ra})
            CNT_INC:  cnt_d = cnt_q + ONE;
            CNT_DEC:  cnt_d = cnt_q - ONE;
            CNT_HOLD: cnt_d = cnt_q;
            default:  cnt_d = cnt_q;
         endcase
         ovf_d = (ovf_q & ~clr_err) | (w_en & full);
         udf_d = (udf_q & ~clr_err) | (r_en & empty);
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   sync_fifo_ram #(
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (w_ptr_q[AW-1:0]),
      .wdata (w_data),
      .re    (ram_re),
      .rclr  (ram_clr),
      .raddr (r_ptr_q[AW-1:0]),
      .rdata (ram_rd)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign r_data = empty ? '0 : ram_rd;
`else
   assign r_data = ram_rd;
`endif

endmodule
